// File: rtl/spi_target.sv
// SPI mode-0 target: synchronised host pins, 1-entry TX holding register, RX byte FIFO.
// Define SPI_TARGET_OVF_COUNT_EN to add the saturating rx_overflow_count_o output.
module spi_target #(
  parameter int         RxDepth  = 4,
  parameter logic [7:0] FillByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_csb_i,
  input  logic       spi_sd_i,
  output logic       spi_sd_o,
  output logic       spi_sd_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       rx_overflow_o,
  output logic       tx_underrun_o,
  input  logic       clear_i
`ifdef SPI_TARGET_OVF_COUNT_EN
  ,
  output logic [7:0] rx_overflow_count_o
`endif
);

  localparam int          AW       = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RxDepth);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state, state_next;

  logic [2:0]    sck_s, csb_s;
  logic [1:0]    sd_s;
  logic          sck_rise, sck_fall, csb_fall, csb_rise, sd_sync;
  logic          enter_active, active;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_shift;
  logic [7:0]    tx_shift, next_tx;
  logic          reload_pend, fill_pend;
  logic          hold_full, hold_wr, hold_load;
  logic [7:0]    hold_data;
  logic          vld_p0, vld_p1;
  logic [7:0]    rx_byte_p0, rx_byte_p1;
  logic [7:0]    mem [RxDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, full, accept, drop, unf_set;

  // Stage boundary: host pins -> two-flop synchronisers plus edge-detect flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_s <= 3'b000;
      csb_s <= 3'b111;
      sd_s  <= 2'b00;
    end else begin
      sck_s <= {sck_s[1:0], spi_sck_i};
      csb_s <= {csb_s[1:0], spi_csb_i};
      sd_s  <= {sd_s[0], spi_sd_i};
    end
  end

  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign csb_fall = ~csb_s[1] & csb_s[2];
  assign csb_rise = csb_s[1] & ~csb_s[2];
  assign sd_sync  = sd_s[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (csb_fall) state_next = ACTIVE;
      ACTIVE: if (csb_rise) state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state == ACTIVE);
    spi_sd_en_o = (state == ACTIVE);
    spi_sd_o    = (state == ACTIVE) & tx_shift[7];
  end

  assign enter_active = (state == IDLE) && csb_fall;
  assign active       = (state == ACTIVE);
  assign next_tx      = hold_full ? hold_data : FillByte;

  // Stage boundary: synchronised edges -> shift registers and bit counter.
  // A fill byte loaded after the last byte only counts as an underrun once the host clocks it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      reload_pend <= 1'b0;
      fill_pend   <= 1'b0;
    end else if (enter_active) begin
      bit_cnt     <= 3'd0;
      tx_shift    <= next_tx;
      reload_pend <= 1'b0;
      fill_pend   <= 1'b0;
    end else if (active && sck_rise) begin
      rx_shift  <= {rx_shift[5:0], sd_sync};
      bit_cnt   <= bit_cnt + 3'd1;
      fill_pend <= 1'b0;
      if (bit_cnt == 3'd7) reload_pend <= 1'b1;
    end else if (active && sck_fall) begin
      if (reload_pend) begin
        tx_shift    <= next_tx;
        reload_pend <= 1'b0;
        fill_pend   <= ~hold_full;
      end else begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign hold_wr   = tx_valid_i && !hold_full;
  assign hold_load = hold_full && (enter_active || (active && sck_fall && reload_pend));
  assign tx_ready_o = ~hold_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          hold_full <= 1'b0;
    else if (hold_wr)   hold_full <= 1'b1;
    else if (hold_load) hold_full <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (hold_wr) hold_data <= tx_data_i;
  end

  // Stage boundary: completed byte -> p0 -> p1 -> FIFO write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= active && sck_rise && (bit_cnt == 3'd7);
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_byte_p0 <= {rx_shift, sd_sync};
    rx_byte_p1 <= rx_byte_p0;
  end

  assign push       = vld_p1;
  assign rx_valid_o = (count != '0);
  assign pop        = rx_valid_o && rx_ready_i;
  assign full       = (count == FULL_CNT);
  assign accept     = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= rx_byte_p1;
  end

  assign unf_set = (enter_active && !hold_full) || (active && sck_rise && fill_pend);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      if (drop)         rx_overflow_o <= 1'b1;
      else if (clear_i) rx_overflow_o <= 1'b0;
      if (unf_set)      tx_underrun_o <= 1'b1;
      else if (clear_i) tx_underrun_o <= 1'b0;
    end
  end

`ifdef SPI_TARGET_OVF_COUNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_overflow_count_o <= 8'd0;
    end else if (drop) begin
      if (rx_overflow_count_o != 8'hFF) rx_overflow_count_o <= rx_overflow_count_o + 8'd1;
    end else if (clear_i) begin
      rx_overflow_count_o <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: host-side SPI mode-0 driver with hand-computed expectations.
module tb_spi_target;

  logic       clk_i = 1'b0;
  logic       rst_i, spi_sck_i, spi_csb_i, spi_sd_i;
  logic       spi_sd_o, spi_sd_en_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready_i;
  logic       busy_o, rx_overflow_o, tx_underrun_o, clear_i;
`ifdef SPI_TARGET_OVF_COUNT_EN
  logic [7:0] rx_overflow_count_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] host_tx [0:7];
  logic [7:0] host_rx [0:7];

  spi_target #(.RxDepth(4), .FillByte(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .spi_sck_i(spi_sck_i), .spi_csb_i(spi_csb_i), .spi_sd_i(spi_sd_i),
    .spi_sd_o(spi_sd_o), .spi_sd_en_o(spi_sd_en_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .rx_overflow_o(rx_overflow_o), .tx_underrun_o(tx_underrun_o),
    .clear_i(clear_i)
`ifdef SPI_TARGET_OVF_COUNT_EN
    , .rx_overflow_count_o(rx_overflow_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {9'd0, spi_sd_o, spi_sd_en_o, tx_ready_o, rx_valid_o, busy_o,
                        rx_overflow_o, tx_underrun_o}, 16'b0010000);
    chk({tag, "_rxdata"}, {8'd0, rx_data_o}, 16'h0000);
`ifdef SPI_TARGET_OVF_COUNT_EN
    chk({tag, "_ovfcnt"}, {8'd0, rx_overflow_count_o}, 16'h0000);
`endif
  endtask

  task automatic queue_tx(input logic [7:0] b);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {7'd0, rx_valid_o, rx_data_o}, {7'd0, 1'b1, exp});
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  // SCK held 4 clocks low and 5 clocks high per bit; changes land on clk falling edges.
  task automatic xfer(input int nbits, input bit chk_lat, input bit pop_last);
    spi_csb_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("busy_in_xfer", {15'd0, busy_o}, 16'd1);
    for (int k = 0; k < nbits; k++) begin
      spi_sd_i = host_tx[k/8][7-(k%8)];
      repeat (4) @(negedge clk_i);
      host_rx[k/8][7-(k%8)] = spi_sd_o;
      spi_sck_i = 1'b1;
      repeat (4) @(negedge clk_i);
      if (k == nbits - 1) begin
        if (chk_lat)  chk("rx_valid_before_lat", {15'd0, rx_valid_o}, 16'd0);
        if (pop_last) rx_ready_i = 1'b1;
      end
      @(negedge clk_i);
      if (k == nbits - 1) begin
        if (chk_lat)  chk("rx_valid_at_lat", {15'd0, rx_valid_o}, 16'd1);
        if (pop_last) rx_ready_i = 1'b0;
      end
      spi_sck_i = 1'b0;
    end
    repeat (4) @(negedge clk_i);
    spi_csb_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; spi_sck_i = 1'b0; spi_csb_i = 1'b1; spi_sd_i = 1'b0;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b0; clear_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Single byte with TX queued, RX latency checked
    queue_tx(8'hA5);
    chk("tx_ready_full", {15'd0, tx_ready_o}, 16'd0);
    host_tx[0] = 8'h3C;
    xfer(8, 1'b1, 1'b0);
    chk("host_rx_a5", {8'd0, host_rx[0]}, 16'h00A5);
    chk("underrun_clean", {15'd0, tx_underrun_o}, 16'd0);
    chk("tx_ready_drained", {15'd0, tx_ready_o}, 16'd1);
    pop_chk("rx_3c", 8'h3C);
    chk("rx_empty_1", {15'd0, rx_valid_o}, 16'd0);

    // Two bytes with nothing queued: fill bytes and underrun
    host_tx[0] = 8'h12; host_tx[1] = 8'h34;
    xfer(16, 1'b0, 1'b0);
    chk("host_rx_fill0", {8'd0, host_rx[0]}, 16'h00FF);
    chk("host_rx_fill1", {8'd0, host_rx[1]}, 16'h00FF);
    chk("underrun_set", {15'd0, tx_underrun_o}, 16'd1);
    pop_chk("rx_12", 8'h12);
    pop_chk("rx_34", 8'h34);
    pulse_clear();
    chk("underrun_cleared", {15'd0, tx_underrun_o}, 16'd0);

    // Five bytes into a depth-4 FIFO with no pops: overflow
    for (int i = 0; i < 5; i++) host_tx[i] = 8'(i + 1);
    xfer(40, 1'b0, 1'b0);
    chk("overflow_set", {15'd0, rx_overflow_o}, 16'd1);
`ifdef SPI_TARGET_OVF_COUNT_EN
    chk("overflow_count", {8'd0, rx_overflow_count_o}, 16'd1);
`endif
    pop_chk("ovf_rx0", 8'h01);
    pop_chk("ovf_rx1", 8'h02);
    pop_chk("ovf_rx2", 8'h03);
    pop_chk("ovf_rx3", 8'h04);
    chk("rx_empty_2", {15'd0, rx_valid_o}, 16'd0);
    pulse_clear();
    chk("overflow_cleared", {15'd0, rx_overflow_o}, 16'd0);

    // Full FIFO popped in the same cycle as the fifth push: no overflow
    host_tx[0] = 8'h11; host_tx[1] = 8'h22; host_tx[2] = 8'h33;
    host_tx[3] = 8'h44; host_tx[4] = 8'h55;
    xfer(40, 1'b0, 1'b1);
    chk("no_overflow_push_pop", {15'd0, rx_overflow_o}, 16'd0);
    pop_chk("pp_rx1", 8'h22);
    pop_chk("pp_rx2", 8'h33);
    pop_chk("pp_rx3", 8'h44);
    pop_chk("pp_rx4", 8'h55);
    chk("rx_empty_3", {15'd0, rx_valid_o}, 16'd0);

    // Chip select raised after 5 bits, then a clean byte
    host_tx[0] = 8'hAB;
    xfer(5, 1'b0, 1'b0);
    chk("abort_idle", {14'd0, busy_o, spi_sd_en_o}, 16'd0);
    chk("abort_no_push", {15'd0, rx_valid_o}, 16'd0);
    chk("abort_no_ovf", {15'd0, rx_overflow_o}, 16'd0);
    host_tx[0] = 8'h81;
    xfer(8, 1'b0, 1'b0);
    pop_chk("rx_81", 8'h81);

    // Reset pulsed mid-byte with a TX byte held
    spi_csb_i = 1'b0;
    repeat (8) @(negedge clk_i);
    queue_tx(8'h77);
    chk("tx_ready_held", {15'd0, tx_ready_o}, 16'd0);
    for (int b = 0; b < 2; b++) begin
      spi_sd_i  = 1'b1;
      repeat (4) @(negedge clk_i);
      spi_sck_i = 1'b1;
      repeat (4) @(negedge clk_i);
      spi_sck_i = 1'b0;
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("mid_reset");
    spi_csb_i = 1'b1;
    spi_sck_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("post_reset_idle", {15'd0, busy_o}, 16'd0);
    queue_tx(8'h3C);
    host_tx[0] = 8'h55;
    xfer(8, 1'b0, 1'b0);
    chk("post_reset_host_rx", {8'd0, host_rx[0]}, 16'h003C);
    chk("post_reset_underrun", {15'd0, tx_underrun_o}, 16'd0);
    pop_chk("post_reset_rx_55", 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
